goomba_tile_arbiter: RTL

Shares the single background tile-lookup path between NUM_GOOMBAS goomba movers. Each mover requests one tile by (row, col) and gets the tile byte back. A round-robin arbiter serialises the requests through one registered address/data port into the background array. The block sits between the per-goomba left/right movers and the background map, and runs on vga_clock.

---
 rtl/goomba_pkg.sv | 28 ++
 rtl/rr_pick.sv | 33 +++
 rtl/goomba_tile_arbiter.sv | 89 ++++++++
 3 files changed

// File: rtl/goomba_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | goomba_pkg : shared tile codes, map geometry and arbiter types   |
// | rev 1.0                                                          |
// +-----------------------------------------------------------------+
package goomba_pkg;

  typedef logic [7:0] tile_t;
  typedef logic [3:0] row_t;
  typedef logic [4:0] col_t;

  localparam tile_t BDR = 8'd0;
  localparam tile_t SKY = 8'd1;
  localparam tile_t BLK = 8'd2;
  localparam tile_t GND = 8'd3;

  localparam int ROWS        = 12;
  localparam int COLS        = 17;
  localparam int BLOCK_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | rr_pick : combinational round-robin selector, search after last  |
// | rev 1.0                                                          |
// +-----------------------------------------------------------------+
module rr_pick #(
  parameter int N    = 4,
  parameter int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] last,
  output logic [IDXW-1:0] winner,
  output logic            found
);

  logic [IDXW-1:0] cand;

  // Scan last+1 .. last+N (mod N); the first asserted request wins.
  always_comb begin
    winner = last;
    found  = 1'b0;
    cand   = '0;
    for (int off = 1; off <= N; off++) begin
      cand = IDXW'((int'(last) + off) % N);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/goomba_tile_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | goomba_tile_arbiter : round-robin share of the background lookup |
// | rev 1.0                                                          |
// +-----------------------------------------------------------------+
module goomba_tile_arbiter #(
  parameter int                NUM_GOOMBAS = 4,
  parameter int                ROWS        = goomba_pkg::ROWS,
  parameter int                COLS        = goomba_pkg::COLS,
  parameter goomba_pkg::tile_t BDR         = goomba_pkg::BDR,
  parameter int                IDXW        = $clog2(NUM_GOOMBAS)
) (
  input  logic                        vga_clock,
  input  logic                        reset,
  input  logic [NUM_GOOMBAS-1:0]      req,
  input  logic [NUM_GOOMBAS-1:0][3:0] req_row,
  input  logic [NUM_GOOMBAS-1:0][4:0] req_col,
  output logic [3:0]                  tile_row,
  output logic [4:0]                  tile_col,
  input  logic [7:0]                  tile_data,
  output logic [NUM_GOOMBAS-1:0]      resp_valid,
  output logic [7:0]                  resp_tile,
  output logic                        busy,
  output logic [IDXW-1:0]             grant_idx
);

  import goomba_pkg::*;

  localparam logic [IDXW-1:0] LAST_RST = IDXW'(NUM_GOOMBAS - 1);

  arb_state_t      state;
  logic            oor;
  logic [IDXW-1:0] pick;
  logic            pick_found;

  rr_pick #(
    .N    (NUM_GOOMBAS),
    .IDXW (IDXW)
  ) u_rr_pick (
    .req    (req),
    .last   (grant_idx),
    .winner (pick),
    .found  (pick_found)
  );

  always_ff @(posedge vga_clock) begin
    if (reset) begin
      state      <= IDLE;
      tile_row   <= '0;
      tile_col   <= '0;
      oor        <= 1'b0;
      resp_valid <= '0;
      resp_tile  <= '0;
      busy       <= 1'b0;
      grant_idx  <= LAST_RST;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_idx <= pick;
            tile_row  <= req_row[pick];
            tile_col  <= req_col[pick];
            oor       <= (int'(req_row[pick]) >= ROWS) || (int'(req_col[pick]) >= COLS);
            busy      <= 1'b1;
            state     <= ADDR;
          end
        end
        ADDR: begin
          // Raw indices still go to the array; only the returned byte is masked.
          resp_tile  <= oor ? BDR : tile_data;
          resp_valid <= NUM_GOOMBAS'(1) << grant_idx;
          state      <= DATA;
        end
        DATA: begin
          resp_valid <= '0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          resp_valid <= '0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
